// File: rtl/snoop_bus_controller.sv
// Snooping bus sequencer for three processor caches and main memory.
// Round-robin grant, one-cycle snoop broadcast, optional dirty-owner
// write-back, fixed-latency memory read and a one-cycle done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; picks the round-robin winner
// ADDR   | broadcasting msg/tag, sampling snoop responses
// WBK    | writing dirty-owner (or evicted requester) data to memory
// MEM    | memory read in flight, MEM_LAT cycles
// DONE   | completion pulse to the granted cache
module snoop_bus_controller #(
  parameter int         TAG_W   = 2,
  parameter int         DATA_W  = 4,
  parameter int         MEM_LAT = 2,
  parameter logic [1:0] RM      = 2'd1,
  parameter logic [1:0] WM      = 2'd2,
  parameter logic [1:0] WB      = 2'd3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [2:0]          req,
  input  logic [5:0]          req_msg,
  input  logic [3*TAG_W-1:0]  req_tag,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [2:0]          snoop_hit,
  input  logic [2:0]          snoop_dirty,
  input  logic [3*DATA_W-1:0] snoop_data,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          gnt,
  output logic                bus_valid,
  output logic [1:0]          bus_msg,
  output logic [1:0]          bus_proc,
  output logic [TAG_W-1:0]    bus_tag,
  output logic                mem_re,
  output logic                mem_we,
  output logic [TAG_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [2:0]          done,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_shared,
  output logic                busy,
  output logic                err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WBK, S_MEM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          msg_q, msg_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                shared_q, shared_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [2:0]          gnt_q, gnt_d;
  logic                bus_valid_q, bus_valid_d;
  logic [1:0]          bus_msg_q, bus_msg_d;
  logic [1:0]          bus_proc_q, bus_proc_d;
  logic [TAG_W-1:0]    bus_tag_q, bus_tag_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [TAG_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          done_q, done_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_shared_q, resp_shared_d;
  logic                busy_q, busy_d;

  // Per-cache views of the packed request/snoop buses.
  logic [1:0]        msg_a   [3];
  logic [TAG_W-1:0]  tag_a   [3];
  logic [DATA_W-1:0] data_a  [3];
  logic [DATA_W-1:0] sdata_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_unpack
    assign msg_a[g]   = req_msg[2*g +: 2];
    assign tag_a[g]   = req_tag[g*TAG_W +: TAG_W];
    assign data_a[g]  = req_data[g*DATA_W +: DATA_W];
    assign sdata_a[g] = snoop_data[g*DATA_W +: DATA_W];
  end

  // First set request bit at or above the pointer, wrapping mod 3.
  // Scanning from the far end means the nearest hit is written last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      int j;
      j = (int'(p) + i) % 3;
      if (r[2'(j)]) w = 2'(j);
    end
    return w;
  endfunction

  logic [1:0] win;
  logic [2:0] hit_m, dirty_m;
  logic [1:0] dsel;
  logic       multi_dirty;

  // Snoop masking and owner selection; the requester never snoops itself.
  always_comb begin
    win         = rr_pick(req, ptr_q);
    hit_m       = snoop_hit & ~gnt_q;
    dirty_m     = snoop_dirty & ~gnt_q;
    dsel        = dirty_m[0] ? 2'd0 : (dirty_m[1] ? 2'd1 : 2'd2);
    multi_dirty = (dirty_m & (dirty_m - 3'd1)) != 3'd0;
  end

  // Next-state and next-output computation; outputs are registered from state_d.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    msg_d         = msg_q;
    tag_d         = tag_q;
    data_d        = data_q;
    shared_d      = shared_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    mem_wdata_d   = '0;
    resp_data_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          idx_d   = win;
          msg_d   = msg_a[win];
          tag_d   = tag_a[win];
          data_d  = data_a[win];
          ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        shared_d = |hit_m;
        if (msg_q == RM || msg_q == WM) begin
          if (dirty_m != 3'b000) begin
            mem_wdata_d = sdata_a[dsel];
            err_d       = err_q | multi_dirty;
            state_d     = S_WBK;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_MEM;
          end
        end else if (msg_q == WB) begin
          mem_wdata_d = data_q;
          state_d     = S_WBK;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WBK: begin
        if (msg_q == WB) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (cnt_q == '0) begin
          resp_data_d = mem_rdata;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    gnt_d         = (state_d != S_IDLE) ? (3'b001 << idx_d) : 3'b000;
    bus_valid_d   = (state_d == S_ADDR);
    bus_msg_d     = (state_d == S_ADDR) ? msg_d : 2'd0;
    bus_proc_d    = (state_d == S_ADDR) ? idx_d : 2'd0;
    bus_tag_d     = (state_d == S_ADDR) ? tag_d : '0;
    mem_we_d      = (state_d == S_WBK);
    mem_re_d      = (state_d == S_MEM);
    mem_addr_d    = (state_d == S_WBK || state_d == S_MEM) ? tag_d : '0;
    done_d        = (state_d == S_DONE) ? gnt_d : 3'b000;
    resp_shared_d = (state_d == S_DONE) ? shared_d : 1'b0;
    busy_d        = (state_d != S_IDLE);
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ptr_q         <= 2'd0;
      idx_q         <= 2'd0;
      msg_q         <= 2'd0;
      tag_q         <= '0;
      data_q        <= '0;
      shared_q      <= 1'b0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      gnt_q         <= 3'b000;
      bus_valid_q   <= 1'b0;
      bus_msg_q     <= 2'd0;
      bus_proc_q    <= 2'd0;
      bus_tag_q     <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      done_q        <= 3'b000;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      msg_q         <= msg_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      shared_q      <= shared_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      gnt_q         <= gnt_d;
      bus_valid_q   <= bus_valid_d;
      bus_msg_q     <= bus_msg_d;
      bus_proc_q    <= bus_proc_d;
      bus_tag_q     <= bus_tag_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      done_q        <= done_d;
      resp_data_q   <= resp_data_d;
      resp_shared_q <= resp_shared_d;
      busy_q        <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign bus_valid   = bus_valid_q;
  assign bus_msg     = bus_msg_q;
  assign bus_proc    = bus_proc_q;
  assign bus_tag     = bus_tag_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign done        = done_q;
  assign resp_data   = resp_data_q;
  assign resp_shared = resp_shared_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller with a completion scoreboard.
module tb_snoop_bus_controller;

  localparam int TAG_W   = 2;
  localparam int DATA_W  = 4;
  localparam int MEM_LAT = 2;
  localparam logic [1:0] RM = 2'd1;
  localparam logic [1:0] WB = 2'd3;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic [2:0]          req = '0;
  logic [5:0]          req_msg = '0;
  logic [3*TAG_W-1:0]  req_tag = '0;
  logic [3*DATA_W-1:0] req_data = '0;
  logic [2:0]          snoop_hit = '0;
  logic [2:0]          snoop_dirty = '0;
  logic [3*DATA_W-1:0] snoop_data = '0;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic [2:0]          gnt;
  logic                bus_valid;
  logic [1:0]          bus_msg;
  logic [1:0]          bus_proc;
  logic [TAG_W-1:0]    bus_tag;
  logic                mem_re;
  logic                mem_we;
  logic [TAG_W-1:0]    mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [2:0]          done;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_shared;
  logic                busy;
  logic                err;

  always #5 clock = ~clock;

  snoop_bus_controller #(.TAG_W(TAG_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_msg(req_msg), .req_tag(req_tag),
    .req_data(req_data), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_data(snoop_data), .mem_rdata(mem_rdata), .gnt(gnt), .bus_valid(bus_valid),
    .bus_msg(bus_msg), .bus_proc(bus_proc), .bus_tag(bus_tag), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .resp_data(resp_data), .resp_shared(resp_shared), .busy(busy), .err(err)
  );

  logic [27:0] all_out;
  assign all_out = {gnt, bus_valid, bus_msg, bus_proc, bus_tag, mem_re, mem_we, mem_addr,
                    mem_wdata, done, resp_data, resp_shared, busy, err};

  typedef struct {
    logic [1:0] idx;
    logic [3:0] data;
    logic       shared;
  } sb_t;
  sb_t sb[$];

  int n_vec = 0;
  int n_miss = 0;

  int          re_cnt, we_cnt, span, gcyc;
  logic [31:0] we_addr, we_data, re_addr, bmsg, btag;
  logic [3:0]  rd_final;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] msg, input logic [1:0] tag,
                         input logic [3:0] data);
    req_msg[2*i +: 2]          = msg;
    req_tag[i*TAG_W +: TAG_W]  = tag;
    req_data[i*DATA_W +: DATA_W] = data;
  endtask

  // Steps negedges until a done pulse, recording bus/memory activity,
  // then pops the scoreboard and checks the completion.
  task automatic run_txn(input string tag, input int budget);
    bit  got;
    sb_t e;
    got = 0; gcyc = 0; span = 0; re_cnt = 0; we_cnt = 0;
    we_addr = '0; we_data = '0; re_addr = '0; bmsg = '0; btag = '0;
    mem_rdata = ~rd_final;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (bus_valid) begin gcyc = c; bmsg = 32'(bus_msg); btag = 32'(bus_tag); end
      if (mem_re) begin re_cnt++; re_addr = 32'(mem_addr); end
      if (mem_we) begin we_cnt++; we_addr = 32'(mem_addr); we_data = 32'(mem_wdata); end
      mem_rdata = (re_cnt == MEM_LAT) ? rd_final : ~rd_final;
      if (done !== 3'b000) begin
        got = 1;
        span = c - gcyc;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, "_done"}, done, 3'b001 << e.idx);
          chk({tag, "_gnt_held"}, gnt, 3'b001 << e.idx);
          chk({tag, "_resp_data"}, resp_data, e.data);
          chk({tag, "_resp_shared"}, resp_shared, e.shared);
        end
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
  endtask

  initial begin
    #1 chk("reset_outputs", all_out, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // single read miss, no snoop hits
    set_req(0, RM, 2'd2, 4'h0);
    req = 3'b001; rd_final = 4'hA;
    sb.push_back('{2'd0, 4'hA, 1'b0});
    run_txn("t1", 20);
    req = 3'b000;
    chk("t1_gnt_cycle", gcyc, 1);
    chk("t1_span", span, MEM_LAT + 1);
    chk("t1_bus_msg", bmsg, 1);
    chk("t1_bus_tag", btag, 2);
    chk("t1_re_cnt", re_cnt, MEM_LAT);
    chk("t1_re_addr", re_addr, 2);
    chk("t1_we_cnt", we_cnt, 0);
    @(negedge clock);
    chk("t1_idle_after", busy, 0);

    @(negedge clock);
    resetn = 1'b0;
    #1 chk("reset_pulse_outputs", all_out, 0);
    @(negedge clock);
    resetn = 1'b1;

    // all three request continuously: order 0,1,2,0
    set_req(0, RM, 2'd0, 4'h0);
    set_req(1, RM, 2'd1, 4'h0);
    set_req(2, RM, 2'd2, 4'h0);
    req = 3'b111; rd_final = 4'hB;
    sb.push_back('{2'd0, 4'hB, 1'b0});
    sb.push_back('{2'd1, 4'hB, 1'b0});
    sb.push_back('{2'd2, 4'hB, 1'b0});
    sb.push_back('{2'd0, 4'hB, 1'b0});
    for (int k = 0; k < 4; k++) begin
      run_txn("t2_rr", 20);
      chk("t2_bus_tag", btag, (k == 3) ? 0 : k);
      chk("t2_span", span, MEM_LAT + 1);
    end
    req = 3'b000;

    // cache 1 read miss, cache 2 owns the line dirty
    set_req(1, RM, 2'd3, 4'h0);
    req = 3'b010;
    snoop_hit = 3'b100; snoop_dirty = 3'b100; snoop_data = {4'h7, 4'h0, 4'h0};
    rd_final = 4'h7;
    sb.push_back('{2'd1, 4'h7, 1'b1});
    run_txn("t3", 20);
    req = 3'b000;
    chk("t3_we_cnt", we_cnt, 1);
    chk("t3_we_addr", we_addr, 3);
    chk("t3_we_data", we_data, 7);
    chk("t3_re_cnt", re_cnt, MEM_LAT);
    chk("t3_span", span, MEM_LAT + 2);
    chk("t3_err", err, 0);

    // cache 0 eviction write-back
    set_req(0, WB, 2'd1, 4'h5);
    req = 3'b001;
    snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
    rd_final = 4'hC;
    sb.push_back('{2'd0, 4'h0, 1'b0});
    run_txn("t4", 20);
    req = 3'b000;
    chk("t4_bus_msg", bmsg, 3);
    chk("t4_we_cnt", we_cnt, 1);
    chk("t4_we_addr", we_addr, 1);
    chk("t4_we_data", we_data, 5);
    chk("t4_re_cnt", re_cnt, 0);
    chk("t4_span", span, 2);

    // two foreign dirty owners plus requester's own bits
    set_req(0, RM, 2'd2, 4'h0);
    req = 3'b001;
    snoop_hit = 3'b111; snoop_dirty = 3'b111; snoop_data = {4'h6, 4'h9, 4'hF};
    rd_final = 4'h9;
    sb.push_back('{2'd0, 4'h9, 1'b1});
    run_txn("t5", 20);
    req = 3'b000;
    chk("t5_we_data", we_data, 9);
    chk("t5_err", err, 1);
    chk("t5_span", span, MEM_LAT + 2);

    // null message from cache 1, err must stay sticky
    set_req(1, 2'd0, 2'd0, 4'h0);
    req = 3'b010;
    snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
    sb.push_back('{2'd1, 4'h0, 1'b0});
    run_txn("t5_null", 20);
    req = 3'b000;
    chk("t5_null_span", span, 1);
    chk("t5_null_strobes", re_cnt + we_cnt, 0);
    @(negedge clock);
    chk("t5_err_sticky", err, 1);

    // reset in the middle of a memory read
    set_req(0, RM, 2'd3, 4'h0);
    req = 3'b001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (mem_re) break;
    end
    chk("t6_reached_mem", mem_re, 1);
    #2 resetn = 1'b0;
    #1 chk("t6_async_clear", all_out, 0);
    set_req(0, RM, 2'd2, 4'h0);
    set_req(2, RM, 2'd1, 4'h0);
    req = 3'b101;
    @(negedge clock);
    chk("t6_held_in_reset", all_out, 0);
    resetn = 1'b1;
    rd_final = 4'hD;
    sb.push_back('{2'd0, 4'hD, 1'b0});
    sb.push_back('{2'd2, 4'hD, 1'b0});
    run_txn("t6_first", 20);
    req = 3'b100;
    run_txn("t6_second", 20);
    req = 3'b000;
    chk("t6_second_tag", btag, 1);
    chk("t6_err_cleared", err, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
